// File: rtl/viterbi_pkg.sv
// ----------------------------------------------------------------------------
// viterbi_pkg
// Constants shared by conv_encoder and viterbi_decoder so that both ends of
// the link always agree on the code: constraint length, generator
// polynomials, frame length and symbol width. Also holds the encoder FSM
// state type and a parity helper.
// ----------------------------------------------------------------------------
package viterbi_pkg;

    localparam int         VIT_K         = 7;
    localparam logic [6:0] VIT_G0        = 7'o171;  // d_out[0] taps, MSB = current bit
    localparam logic [6:0] VIT_G1        = 7'o133;  // d_out[1] taps, MSB = current bit
    localparam int         VIT_FRAME_LEN = 642;     // information bits per frame
    localparam int         VIT_SYM_W     = 2;       // rate-1/2 coded symbol width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_TAIL = 2'd2
    } enc_state_e;

    // Parity of the tapped bits of an encoder vector.
    function automatic logic parity(input logic [VIT_K-1:0] v,
                                    input logic [VIT_K-1:0] g);
        return ^(v & g);
    endfunction

endpackage

// File: rtl/conv_encoder.sv
// ----------------------------------------------------------------------------
// conv_encoder
// Rate-1/2 convolutional encoder feeding viterbi_decoder. Information bits are
// taken under a valid/ready handshake and framed into FRAME_LEN-bit blocks;
// every block is followed by K-1 zero tail bits so the trellis ends in state 0.
//
// Ports:
//   clk          in   rising-edge clock
//   RSTn         in   synchronous active-low reset
//   d_in_valid   in   an information bit is offered
//   d_in         in   information bit
//   d_in_ready   out  encoder accepts d_in this cycle (combinational)
//   d_out_valid  out  d_out holds a coded symbol (registered)
//   d_out[1:0]   out  [0]=parity(u&G0), [1]=parity(u&G1) (registered)
//   d_out_last   out  high with the final tail symbol of a frame (registered)
// ----------------------------------------------------------------------------
module conv_encoder
    import viterbi_pkg::*;
#(
    parameter int           K         = VIT_K,
    parameter logic [K-1:0] G0        = VIT_G0,
    parameter logic [K-1:0] G1        = VIT_G1,
    parameter int           FRAME_LEN = VIT_FRAME_LEN
) (
    input  logic                 clk,
    input  logic                 RSTn,
    input  logic                 d_in_valid,
    input  logic                 d_in,
    output logic                 d_in_ready,
    output logic                 d_out_valid,
    output logic [VIT_SYM_W-1:0] d_out,
    output logic                 d_out_last
);

    localparam int BIT_W  = $clog2(FRAME_LEN + 1);
    localparam int TAIL_W = $clog2(K);

    enc_state_e         r_state;
    logic [K-2:0]       r_sr;        // r_sr[K-2] is the most recent past bit
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [TAIL_W-1:0]  r_tail_cnt;

    logic               w_accept;
    logic               w_cur;
    logic [K-1:0]       w_u;
    logic [VIT_SYM_W-1:0] w_sym;

    // Ready only depends on state, so the upstream sees it stable all cycle.
    assign d_in_ready = RSTn && (r_state != ST_TAIL);
    assign w_accept   = d_in_valid && d_in_ready;

    // Tail bits are forced to zero regardless of d_in.
    assign w_cur = (r_state == ST_TAIL) ? 1'b0 : d_in;
    assign w_u   = {w_cur, r_sr};
    assign w_sym = {^(w_u & G1), ^(w_u & G0)};

    always_ff @(posedge clk) begin
        if (!RSTn) begin
            r_state     <= ST_IDLE;
            r_sr        <= '0;
            r_bit_cnt   <= '0;
            r_tail_cnt  <= '0;
            d_out_valid <= 1'b0;
            d_out       <= '0;
            d_out_last  <= 1'b0;
        end else begin
            d_out_valid <= 1'b0;
            d_out_last  <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DATA: begin
                    // IDLE has r_bit_cnt==0 and r_sr==0, so both share the
                    // same encode/count path.
                    if (w_accept) begin
                        r_sr        <= w_u[K-1:1];
                        d_out       <= w_sym;
                        d_out_valid <= 1'b1;
                        r_bit_cnt   <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == BIT_W'(FRAME_LEN - 1)) begin
                            r_state    <= ST_TAIL;
                            r_tail_cnt <= '0;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_TAIL: begin
                    r_sr        <= w_u[K-1:1];
                    d_out       <= w_sym;
                    d_out_valid <= 1'b1;
                    if (r_tail_cnt == TAIL_W'(K - 2)) begin
                        // K-1 zeros have been shifted in: r_sr is now zero.
                        d_out_last <= 1'b1;
                        r_bit_cnt  <= '0;
                        r_tail_cnt <= '0;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_tail_cnt <= r_tail_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_encoder.sv
// ----------------------------------------------------------------------------
// tb_conv_encoder
// Random-stimulus bench for conv_encoder. Expected symbols come from a direct
// convolution of each frame (info bits plus K-1 zeros) with the generator
// polynomials. A second instance with FRAME_LEN=1 covers the impulse response.
// ----------------------------------------------------------------------------
module tb_conv_encoder;

    localparam int         K   = 7;
    localparam logic [6:0] G0  = 7'o171;
    localparam logic [6:0] G1  = 7'o133;
    localparam int         FL  = 642;
    localparam int         NSYM = FL + K - 1;

    logic       clk = 1'b0;
    logic       RSTn;
    logic       d_in_valid, d_in, d_in_ready;
    logic       d_out_valid, d_out_last;
    logic [1:0] d_out;

    logic       d1_valid, d1_in, d1_ready;
    logic       d1_out_valid, d1_out_last;
    logic [1:0] d1_out;

    always #5 clk = ~clk;

    conv_encoder dut (
        .clk(clk), .RSTn(RSTn),
        .d_in_valid(d_in_valid), .d_in(d_in), .d_in_ready(d_in_ready),
        .d_out_valid(d_out_valid), .d_out(d_out), .d_out_last(d_out_last)
    );

    conv_encoder #(.FRAME_LEN(1)) dut1 (
        .clk(clk), .RSTn(RSTn),
        .d_in_valid(d1_valid), .d_in(d1_in), .d_in_ready(d1_ready),
        .d_out_valid(d1_out_valid), .d_out(d1_out), .d_out_last(d1_out_last)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitors, sampled on the falling edge.
    int         cyc = 0;
    logic [1:0] sym_q[$];
    bit         last_q[$];
    int         cyc_q[$];
    int         rdy_low = 0;
    logic [1:0] sym1_q[$];
    bit         last1_q[$];
    int         rdy1_low = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (d_out_valid) begin
            sym_q.push_back(d_out);
            last_q.push_back(d_out_last);
            cyc_q.push_back(cyc);
        end
        if (d1_out_valid) begin
            sym1_q.push_back(d1_out);
            last1_q.push_back(d1_out_last);
        end
        if (RSTn && !d_in_ready) rdy_low++;
        if (RSTn && !d1_ready)   rdy1_low++;
    end

    task automatic clear_mon();
        sym_q.delete(); last_q.delete(); cyc_q.delete();
        sym1_q.delete(); last1_q.delete();
        rdy_low = 0; rdy1_low = 0;
    endtask

    // Reference: symbol i is the convolution of the tail-padded frame with
    // G0/G1, where tap j (0 = current bit) uses polynomial bit K-1-j.
    logic [1:0] exp_q[$];

    task automatic build_exp(input bit info[$]);
        bit full[$];
        full = info;
        repeat (K - 1) full.push_back(1'b0);
        for (int i = 0; i < full.size(); i++) begin
            logic [1:0] s;
            s = 2'b00;
            for (int j = 0; j < K; j++)
                if (i - j >= 0 && full[i-j]) begin
                    s[0] = s[0] ^ G0[K-1-j];
                    s[1] = s[1] ^ G1[K-1-j];
                end
            exp_q.push_back(s);
        end
    endtask

    // Compare one frame's worth of expected symbols starting at sym_q[base].
    task automatic cmp_frame(input string tag, input int base, input int ebase);
        int bad_sym = 0;
        int bad_last = 0;
        for (int i = 0; i < NSYM; i++) begin
            if (base + i >= sym_q.size()) begin
                bad_sym++;
            end else begin
                if (sym_q[base+i] !== exp_q[ebase+i]) bad_sym++;
                if (last_q[base+i] !== (i == NSYM - 1)) bad_last++;
            end
        end
        chk({tag, "_sym_errs"}, bad_sym, 0);
        chk({tag, "_last_errs"}, bad_last, 0);
    endtask

    // Offer one bit and hold it until accepted (bounded).
    task automatic drive_bit(input bit b, input int gap_pct);
        int guard;
        while ($urandom_range(99) < gap_pct) begin
            d_in_valid = 1'b0;
            d_in = 1'($urandom);
            @(posedge clk); #1;
        end
        d_in_valid = 1'b1;
        d_in = b;
        guard = 0;
        while (!d_in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) chk("ready_timeout", 0, 1);
        @(posedge clk); #1;
        d_in_valid = 1'b0;
    endtask

    task automatic drive_frame(input bit bits[$], input int gap_pct);
        foreach (bits[i]) drive_bit(bits[i], gap_pct);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void rand_frame(output bit f[$]);
        f.delete();
        for (int i = 0; i < FL; i++) f.push_back(1'($urandom));
    endfunction

    initial begin
        bit fa[$], fb[$], fz[$], f1[$];
        logic [1:0] imp [7];
        int bad;

        RSTn = 1'b0;
        d_in_valid = 1'b0; d_in = 1'b0;
        d1_valid = 1'b0; d1_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", d_out_valid, 0);
        chk("rst_dout", d_out, 0);
        chk("rst_last", d_out_last, 0);
        chk("rst_ready", d_in_ready, 0);
        chk("rst1_valid", d1_out_valid, 0);
        RSTn = 1'b1;
        #1;
        chk("idle_ready", d_in_ready, 1);
        idle(2);

        // Impulse on the FRAME_LEN=1 instance.
        clear_mon();
        imp = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b00, 2'b10, 2'b11};
        d1_valid = 1'b1; d1_in = 1'b1;
        @(posedge clk); #1;
        d1_valid = 1'b0;
        idle(12);
        chk("imp_count", sym1_q.size(), 7);
        bad = 0;
        for (int i = 0; i < 7 && i < sym1_q.size(); i++) begin
            if (sym1_q[i] !== imp[i]) bad++;
            if (last1_q[i] !== (i == 6)) bad++;
        end
        chk("imp_sym_errs", bad, 0);
        chk("imp_ready_low", rdy1_low, 6);

        // All-zero frame.
        clear_mon(); exp_q.delete();
        fz.delete();
        repeat (FL) fz.push_back(1'b0);
        build_exp(fz);
        drive_frame(fz, 0);
        idle(12);
        chk("zero_count", sym_q.size(), NSYM);
        cmp_frame("zero", 0, 0);
        chk("zero_ready_low", rdy_low, 6);

        // Random frame, gap-free then the same bits with ~30% gaps.
        rand_frame(fa);
        clear_mon(); exp_q.delete();
        build_exp(fa);
        drive_frame(fa, 0);
        idle(12);
        chk("rand_count", sym_q.size(), NSYM);
        cmp_frame("rand", 0, 0);
        clear_mon();
        drive_frame(fa, 30);
        idle(12);
        chk("gap_count", sym_q.size(), NSYM);
        cmp_frame("gap", 0, 0);

        // Two back-to-back random frames.
        rand_frame(fa);
        rand_frame(fb);
        clear_mon(); exp_q.delete();
        build_exp(fa);
        build_exp(fb);
        drive_frame(fa, 0);
        drive_frame(fb, 0);
        idle(12);
        chk("b2b_count", sym_q.size(), 2 * NSYM);
        cmp_frame("b2b_a", 0, 0);
        cmp_frame("b2b_b", NSYM, NSYM);
        if (sym_q.size() > NSYM)
            chk("b2b_bubble", cyc_q[NSYM] - cyc_q[NSYM-1], 1);
        else
            chk("b2b_bubble", 0, 1);

        // Reset for one cycle after bit 300 of a frame.
        rand_frame(fa);
        clear_mon();
        for (int i = 0; i < 300; i++) drive_bit(fa[i], 0);
        RSTn = 1'b0;
        d_in_valid = 1'b1; d_in = 1'b1;
        #1;
        chk("midrst_ready", d_in_ready, 0);
        @(posedge clk); #1;
        d_in_valid = 1'b0;
        chk("midrst_valid", d_out_valid, 0);
        chk("midrst_last", d_out_last, 0);
        RSTn = 1'b1;
        #1;
        chk("midrst_idle_ready", d_in_ready, 1);
        idle(3);
        chk("midrst_no_tail", sym_q.size(), 300);
        rand_frame(fb);
        clear_mon(); exp_q.delete();
        build_exp(fb);
        drive_frame(fb, 10);
        idle(12);
        chk("post_rst_count", sym_q.size(), NSYM);
        cmp_frame("post_rst", 0, 0);

        // All-ones frame: steady-state 11 between warm-up and tail.
        f1.delete();
        repeat (FL) f1.push_back(1'b1);
        clear_mon(); exp_q.delete();
        build_exp(f1);
        drive_frame(f1, 0);
        idle(12);
        chk("ones_count", sym_q.size(), NSYM);
        cmp_frame("ones", 0, 0);
        bad = 0;
        for (int i = K - 1; i < FL && i < sym_q.size(); i++)
            if (sym_q[i] !== 2'b11) bad++;
        chk("ones_steady", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/conv_encoder.md
Name: conv_encoder

Overview:
Rate-1/2 convolutional encoder that sits directly upstream of viterbi_decoder and produces the 2-bit coded symbols the decoder consumes. It accepts a serial information bit stream under a valid/ready handshake and frames it into fixed-length blocks. Each block is terminated with K-1 zero tail bits so that every frame ends in state 0, which is what the decoder's traceback requires. The output symbol stream connects directly to the decoder's d_in_valid/d_in.

Parameters:
K, 7, constraint length; shift register holds K-1 past bits.
G0, 7'o171, generator polynomial for d_out[0]; MSB taps the current bit, LSB taps the oldest bit.
G1, 7'o133, generator polynomial for d_out[1]; same tap ordering.
FRAME_LEN, 642, information bits per frame; each frame emits FRAME_LEN+K-1 symbols (648 at default).

Ports:
clk  in  1  clock, rising-edge.
RSTn  in  1  synchronous active-low reset.
d_in_valid  in  1  an information bit is offered.
d_in  in  1  information bit.
d_in_ready  out  1  encoder accepts d_in this cycle.
d_out_valid  out  1  d_out holds a valid coded symbol; connects to the decoder's d_in_valid.
d_out  out  2  coded symbol; [0]=parity(u&G0), [1]=parity(u&G1).
d_out_last  out  1  high with the final tail symbol of a frame.

Behaviour:
- Reset is synchronous: at a clk edge with RSTn=0, sr=0, bit_cnt=0, tail_cnt=0, state=IDLE, d_out_valid=0, d_out=2'b00, d_out_last=0. Reset mid-frame discards the frame; no partial tail is emitted.
- Encoder vector: u = {cur, sr[K-2:0]}, where sr[K-2] is the most recent past bit. After each encoded bit, sr <= {cur, sr[K-2:1]}.
- Accept: accept = d_in_valid & d_in_ready. d_in_ready is combinational: 1 in IDLE and DATA, 0 in TAIL, 0 while RSTn=0.
- Latency: all outputs are registered. The symbol for a bit accepted at edge n is valid after edge n; one symbol per accepted bit.
- FSM:
  - IDLE: sr=0. On accept, encode the bit, set bit_cnt=1, go to DATA. If FRAME_LEN=1, go straight to TAIL.
  - DATA: on accept, encode and increment bit_cnt. When the accepted bit makes bit_cnt==FRAME_LEN, go to TAIL with tail_cnt=0.
  - TAIL: each cycle, encode cur=0 unconditionally and assert d_out_valid. On tail_cnt==K-2, assert d_out_last, clear bit_cnt, go to IDLE; sr is 0 at that point by construction.
- Input gaps: when d_in_valid=0 in IDLE or DATA, d_out_valid=0 next cycle and sr/bit_cnt are held. d_out keeps its last value but is don't-care.
- Back-to-back frames: a bit offered in the cycle after the last tail symbol is accepted (IDLE, ready=1), so there is zero bubble beyond the tail.
- Output has no backpressure: the decoder accepts every valid symbol.
- Width rules: bit_cnt is $clog2(FRAME_LEN+1) bits, tail_cnt is $clog2(K) bits; neither counter wraps.
- Parity: XOR-reduce of (u & G).

Decomposition:
- Shared package viterbi_pkg: K, G0, G1, FRAME_LEN defaults, symbol width, and a parity function. The decoder imports the same constants so encoder and decoder cannot diverge.
- No sub-module required. The FSM, counters and shift register fit in one module of about 150 lines.

Test Plan:
- Impulse, FRAME_LEN=1, input 1: exactly 7 symbols {d_out[1],d_out[0]} = 11,01,11,11,00,10,11, d_out_last on the 7th, d_in_ready low for cycles 2-7.
- Default frame, all-zero input, 642 bits streamed: 648 symbols all 00, d_out_last on symbol 648, d_in_ready low for exactly 6 cycles.
- Random d_in_valid gaps (about 30% idle): symbol sequence identical to the gap-free run; d_out_valid count = 648; sr unchanged across gaps.
- Two back-to-back frames of random data: second frame's first symbol follows the first frame's d_out_last in the next cycle; both frames match the golden model, which the decoder loopback decodes error-free.
- RSTn=0 for one cycle mid-frame at bit 300: next cycle d_out_valid=0, state IDLE; a new frame then encodes from sr=0 and matches the golden model.
- All-ones frame: after the first 6 symbols, steady-state symbols = 11 until the tail begins.
